coproc_cmd_sched: RTL and testbench

//  Command scheduler between the CPU I/O layer and the image coprocessor. Accepts
//  1-cycle command writes from the COPROC_CTL register, queues them in a small FIFO,

---
 rtl/coproc_cmd_sched_if.sv | 27 ++
 rtl/coproc_cmd_sched.sv | 173 +++++++++++++++++
 tb/tb_coproc_cmd_sched.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/coproc_cmd_sched_if.sv
// Bus bundle between the CPU I/O layer / coprocessor and the command scheduler.
`timescale 1ns/1ps
interface coproc_cmd_sched_if #(
  parameter int CMD_W = 8
);
  logic [CMD_W-1:0] ctl_in;
  logic             sts_rd;
  logic             cp_done;
  logic             cp_start;
  logic [CMD_W-1:0] cp_cmd;
  logic             cp_abort;
  logic [1:0]       sts_out;
  logic             ovf_err;
  logic             tmo_err;

  // Environment side: CPU register writes/reads and coprocessor completion
  modport master (
    output ctl_in, sts_rd, cp_done,
    input  cp_start, cp_cmd, cp_abort, sts_out, ovf_err, tmo_err
  );

  // Scheduler side
  modport slave (
    input  ctl_in, sts_rd, cp_done,
    output cp_start, cp_cmd, cp_abort, sts_out, ovf_err, tmo_err
  );
endinterface

// File: rtl/coproc_cmd_sched.sv
// Command scheduler: queues COPROC_CTL writes, issues them one at a time to the
// image coprocessor with a start/done handshake, and builds COPROC_STS plus the
// sticky overflow/timeout flags.
`timescale 1ns/1ps
module coproc_cmd_sched #(
  parameter int DEPTH       = 4,
  parameter int CMD_W       = 8,
  parameter int TIMEOUT_CYC = 65535
) (
  input logic               clk,
  input logic               rst_n,
  coproc_cmd_sched_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [CMD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [TMR_W-1:0] timer;

  logic             is_abort;
  logic             is_cmd;
  logic             fifo_empty;
  logic             fifo_full;
  logic             pop;
  logic             flush;
  logic             push_ok;
  logic             ovf_set;
  logic             start_nxt;
  logic             abort_nxt;
  logic             tmr_clr;
  logic             tmr_inc;
  logic             done_set;
  logic             tmo_set;

  logic             cp_start_q;
  logic             cp_abort_q;
  logic [CMD_W-1:0] cp_cmd_q;
  logic             done_sticky_q;
  logic             ovf_q;
  logic             tmo_q;

  assign bus.cp_start = cp_start_q;
  assign bus.cp_abort = cp_abort_q;
  assign bus.cp_cmd   = cp_cmd_q;
  assign bus.ovf_err  = ovf_q;
  assign bus.tmo_err  = tmo_q;
  assign bus.sts_out  = {(state != S_IDLE) || (count != '0), done_sticky_q};

  // Next-state decode and the per-cycle strobes driving FIFO, timer and outputs
  always_comb begin
    state_nxt  = state;
    pop        = 1'b0;
    flush      = 1'b0;
    start_nxt  = 1'b0;
    abort_nxt  = 1'b0;
    tmr_clr    = 1'b0;
    tmr_inc    = 1'b0;
    done_set   = 1'b0;
    tmo_set    = 1'b0;
    is_abort   = (bus.ctl_in == '1);
    is_cmd     = (bus.ctl_in != '0) && !is_abort;
    fifo_empty = (count == '0);
    fifo_full  = (count == CNT_FULL);

    if (is_abort) begin
      // ABORT overrides everything, including a done or pop in the same cycle
      flush     = 1'b1;
      abort_nxt = 1'b1;
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (!fifo_empty) state_nxt = S_ISSUE;
        end
        S_ISSUE: begin
          pop       = 1'b1;
          start_nxt = 1'b1;
          tmr_clr   = 1'b1;
          state_nxt = S_WAIT;
        end
        S_WAIT: begin
          if (bus.cp_done) begin
            // A same-cycle push into an empty FIFO is always accepted, so it
            // counts as pending work and suppresses done_sticky
            done_set  = fifo_empty && !is_cmd;
            state_nxt = S_IDLE;
          end else if (timer == TMR_LAST) begin
            tmo_set   = 1'b1;
            abort_nxt = 1'b1;
            flush     = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            tmr_inc = 1'b1;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end

    // A flush discards any command arriving in the same cycle without flagging overflow
    push_ok = is_cmd && !flush && (!fifo_full || pop);
    ovf_set = is_cmd && !flush && fifo_full && !pop;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop);
    end
  end

  // FIFO storage; contents need no reset since the count qualifies them
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= bus.ctl_in;
  end

  // WAIT-state cycle counter for the coprocessor timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       timer <= '0;
    else if (tmr_clr) timer <= '0;
    else if (tmr_inc) timer <= timer + TMR_W'(1);
  end

  // Registered coprocessor strobes, issued command and sticky status (set beats clear)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cp_start_q    <= 1'b0;
      cp_abort_q    <= 1'b0;
      cp_cmd_q      <= '0;
      done_sticky_q <= 1'b0;
      ovf_q         <= 1'b0;
      tmo_q         <= 1'b0;
    end else begin
      cp_start_q    <= start_nxt;
      cp_abort_q    <= abort_nxt;
      if (pop) cp_cmd_q <= mem[rd_ptr];
      done_sticky_q <= done_set | (done_sticky_q & ~bus.sts_rd);
      ovf_q         <= ovf_set  | (ovf_q & ~bus.sts_rd);
      tmo_q         <= tmo_set  | (tmo_q & ~bus.sts_rd);
    end
  end
endmodule

// File: tb/tb_coproc_cmd_sched.sv
// Bench for coproc_cmd_sched: directed scenarios with literal expectations plus a
// randomized run, all compared every cycle against a queue-based reference model.
`timescale 1ns/1ps
module tb_coproc_cmd_sched;
  localparam int DEPTH = 4;
  localparam int CMD_W = 8;
  localparam int TMO   = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  coproc_cmd_sched_if #(.CMD_W(CMD_W)) bus ();

  coproc_cmd_sched #(.DEPTH(DEPTH), .CMD_W(CMD_W), .TIMEOUT_CYC(TMO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: command queue plus "in flight since edge X" bookkeeping
  logic [7:0] mq[$];
  bit         m_active = 0;
  bit         m_pend = 0;
  int         m_edge = 0;
  int         m_start_edge = 0;
  logic [7:0] m_cmd = '0;
  bit         m_start = 0;
  bit         m_abort = 0;
  bit         m_done_st = 0;
  bit         m_ovf = 0;
  bit         m_tmo = 0;

  task automatic model_step();
    logic [7:0] c;
    bit abt, push, popnow, flush, dset, oset, tset;
    int sz;
    c = bus.ctl_in;
    abt = (c == 8'hFF);
    push = (c != 8'h00) && !abt;
    sz = mq.size();
    popnow = 0; flush = 0; dset = 0; oset = 0; tset = 0;
    m_edge++;
    m_start = 0;
    m_abort = 0;
    if (abt) begin
      flush = 1; m_abort = 1; m_active = 0; m_pend = 0;
    end else if (m_pend) begin
      popnow = 1;
    end else if (m_active) begin
      if (bus.cp_done) begin
        m_active = 0;
        dset = (sz == 0) && !push;
      end else if (m_edge - m_start_edge == TMO) begin
        m_active = 0; flush = 1; tset = 1; m_abort = 1;
      end
    end else if (sz > 0) begin
      m_pend = 1;
    end
    if (popnow) begin
      m_cmd = mq.pop_front();
      m_start = 1; m_active = 1; m_pend = 0; m_start_edge = m_edge;
    end
    if (flush) mq.delete();
    else if (push) begin
      if (sz < DEPTH || popnow) mq.push_back(c);
      else oset = 1;
    end
    m_done_st = dset || (m_done_st && !bus.sts_rd);
    m_ovf     = oset || (m_ovf && !bus.sts_rd);
    m_tmo     = tset || (m_tmo && !bus.sts_rd);
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete();
      m_active = 0; m_pend = 0; m_cmd = '0; m_start = 0; m_abort = 0;
      m_done_st = 0; m_ovf = 0; m_tmo = 0;
    end else begin
      model_step();
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n) begin
      chk("cp_start", bus.cp_start, m_start);
      chk("cp_abort", bus.cp_abort, m_abort);
      chk("cp_cmd", bus.cp_cmd, m_cmd);
      chk("sts_out", bus.sts_out, {(m_active || m_pend || mq.size() != 0), m_done_st});
      chk("ovf_err", bus.ovf_err, m_ovf);
      chk("tmo_err", bus.tmo_err, m_tmo);
    end
  end

  logic [7:0] push_q[$];
  logic [7:0] got_q[$];
  int idle_seen;
  int early_done;

  // Feed push_q one per cycle and answer each cp_start with cp_done lat cycles later (lat 0 = never)
  task automatic serve(input int lat, input int ncyc, input int busy_until);
    int dcnt;
    int ndone;
    dcnt = -1;
    ndone = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (c > 0 && ndone < busy_until) begin
        if (!bus.sts_out[1]) idle_seen++;
        if (bus.sts_out[0]) early_done++;
      end
      bus.cp_done = 1'b0;
      if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) begin
          bus.cp_done = 1'b1;
          ndone++;
          dcnt = -1;
        end
      end
      if (bus.cp_start) begin
        got_q.push_back(bus.cp_cmd);
        dcnt = (lat > 0) ? lat - 1 : -1;
      end
      bus.ctl_in = (push_q.size() > 0) ? push_q.pop_front() : 8'h00;
    end
    bus.ctl_in  = 8'h00;
    bus.cp_done = 1'b0;
  endtask

  task automatic clear_sticky();
    @(negedge clk);
    bus.sts_rd = 1'b1;
    @(negedge clk);
    bus.sts_rd = 1'b0;
  endtask

  initial begin
    int n;
    int starts;
    bus.ctl_in = '0;
    bus.sts_rd = 1'b0;
    bus.cp_done = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cp_start", bus.cp_start, 0);
    chk("rst_cp_cmd", bus.cp_cmd, 0);
    chk("rst_sts_out", bus.sts_out, 0);
    chk("rst_errs", {bus.ovf_err, bus.tmo_err, bus.cp_abort}, 0);

    // 1: single command latency, done_sticky, status read clear
    bus.ctl_in = 8'h12;
    @(negedge clk); bus.ctl_in = 8'h00;
    chk("t1_start_n", bus.cp_start, 0);
    @(negedge clk);
    chk("t1_start_n1", bus.cp_start, 0);
    @(negedge clk);
    chk("t1_start_n2", bus.cp_start, 1);
    chk("t1_cmd", bus.cp_cmd, 8'h12);
    @(negedge clk);
    chk("t1_busy", bus.sts_out, 2'b10);
    repeat (3) @(negedge clk);
    bus.cp_done = 1'b1;
    @(negedge clk); bus.cp_done = 1'b0;
    chk("t1_sts_done", bus.sts_out, 2'b01);
    bus.sts_rd = 1'b1;
    @(negedge clk); bus.sts_rd = 1'b0;
    chk("t1_sts_clr", bus.sts_out, 2'b00);

    // 2: four back-to-back commands issue in order, busy throughout
    push_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    got_q.delete(); idle_seen = 0; early_done = 0;
    serve(3, 30, 4);
    chk("t2_count", got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) chk("t2_order", got_q[i], i + 1);
    chk("t2_idle_seen", idle_seen, 0);
    chk("t2_early_done", early_done, 0);
    chk("t2_sts", bus.sts_out, 2'b01);

    // 3: timeout exactly TMO cycles after cp_start, queue flushed
    clear_sticky();
    @(negedge clk); bus.ctl_in = 8'h41;
    @(negedge clk); bus.ctl_in = 8'h42;
    @(negedge clk); bus.ctl_in = 8'h43;
    @(negedge clk); bus.ctl_in = 8'h00;
    n = 0;
    while (n < 10 && !bus.cp_start) begin @(negedge clk); n++; end
    chk("t3_started", bus.cp_start, 1);
    chk("t3_cmd", bus.cp_cmd, 8'h41);
    n = 0;
    while (n < TMO + 5 && !bus.cp_abort) begin @(negedge clk); n++; end
    chk("t3_tmo_cycles", n, TMO);
    chk("t3_tmo_err", bus.tmo_err, 1);
    chk("t3_sts", bus.sts_out, 2'b00);
    starts = 0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); if (bus.cp_start) starts++; end
    chk("t3_no_start", starts, 0);
    clear_sticky();
    @(negedge clk);
    chk("t3_tmo_clr", bus.tmo_err, 0);

    // 4: overflow drops the fifth queued command
    push_q = '{8'h50, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25};
    got_q.delete();
    serve(6, 60, 0);
    chk("t4_ovf", bus.ovf_err, 1);
    chk("t4_count", got_q.size(), 5);
    if (got_q.size() == 5) begin
      chk("t4_c0", got_q[0], 8'h50);
      chk("t4_c4", got_q[4], 8'h24);
    end

    // 5: ABORT flushes queue, later cp_done ignored
    clear_sticky();
    push_q = '{8'h60, 8'h31, 8'h32, 8'h33};
    got_q.delete();
    serve(0, 6, 0);
    bus.ctl_in = 8'hFF;
    @(negedge clk); bus.ctl_in = 8'h00; bus.cp_done = 1'b1;
    chk("t5_abort", bus.cp_abort, 1);
    chk("t5_sts", bus.sts_out, 2'b00);
    chk("t5_issued", got_q.size(), 1);
    @(negedge clk); bus.cp_done = 1'b0;
    chk("t5_abort_pulse", bus.cp_abort, 0);
    chk("t5_done_ign", bus.sts_out, 2'b00);
    starts = 0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (bus.cp_start) starts++; end
    chk("t5_no_start", starts, 0);

    // 6: asynchronous reset mid-WAIT
    push_q = '{8'h70, 8'h71};
    serve(0, 5, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_start", bus.cp_start, 0);
    chk("t6_cmd", bus.cp_cmd, 0);
    chk("t6_sts", bus.sts_out, 0);
    chk("t6_errs", {bus.ovf_err, bus.tmo_err, bus.cp_abort}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.cp_done = 1'b1;
    @(negedge clk); bus.cp_done = 1'b0;
    chk("t6_done_ign", bus.sts_out, 2'b00);
    starts = 0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (bus.cp_start) starts++; end
    chk("t6_no_start", starts, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int r;
      @(negedge clk);
      r = int'($urandom_range(0, 99));
      if (r < 65)      bus.ctl_in = 8'h00;
      else if (r < 97) bus.ctl_in = 8'($urandom_range(1, 254));
      else             bus.ctl_in = 8'hFF;
      bus.sts_rd  = ($urandom_range(0, 9) == 0);
      bus.cp_done = ($urandom_range(0, 99) < 12);
    end
    @(negedge clk);
    bus.ctl_in = 8'h00; bus.sts_rd = 1'b0; bus.cp_done = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end
endmodule
